// File: rtl/pwm_pkg.sv
// PWM shared definitions: register word indices, CTRL/STATUS bit
// positions and capture FSM encoding, shared with generator and software.
package pwm_pkg;

  localparam logic [5:0] IDX_CTRL    = 6'd0;
  localparam logic [5:0] IDX_STATUS  = 6'd1;
  localparam logic [5:0] IDX_HIGH    = 6'd2;
  localparam logic [5:0] IDX_PERIOD  = 6'd3;
  localparam logic [5:0] IDX_EDGES   = 6'd4;
  localparam logic [5:0] IDX_TIMEOUT = 6'd5;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;
  localparam int CTRL_IRQ = 2;
  localparam int CTRL_CLR = 3;

  localparam int ST_VALID = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_STALL = 2;
  localparam int ST_LEVEL = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// PWM input conditioning: 2-flop synchronizer, optional inversion,
// rise/fall detect. Ports: clk_i, rst_i, pwm_i, inv_i -> level_o, rise_o, fall_o.
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  input  logic inv_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic cur;

  assign cur = s2_q ^ inv_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pwm_i;
      s2_q   <= s1_q;
      prev_q <= cur;
    end
  end

  assign level_o = cur;
  assign rise_o  = cur & ~prev_q;
  assign fall_o  = ~cur & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time, period and rising edges of cio_pwm_i.
// Ports: clk_i/rst_i, bus (valid_i, we_i, addr_i, wdata_i, ready_o, rdata_o), cio_pwm_i, irq_o.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            we_i,
  input  logic [BITS-1:0] addr_i,
  input  logic [BITS-1:0] wdata_i,
  output logic            ready_o,
  output logic [BITS-1:0] rdata_o,
  input  logic            cio_pwm_i,
  output logic            irq_o
);

  logic            ready_q;
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            en_q, en_d;
  logic            inv_q, inv_d;
  logic            irqen_q, irqen_d;
  logic            vld_q, vld_d;
  logic            ovf_q, ovf_d;
  logic            stl_q, stl_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     per_q, per_d;
  logic [31:0]     edg_q, edg_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [31:0]     cp_q, cp_d;
  logic [31:0]     ch_q, ch_d;
  logic [1:0]      st_q, st_d;

  logic        level, rise, fall;
  logic        acc, wr, rd;
  logic [5:0]  idx;
  logic [31:0] wd, rmux;
  logic        wr_ctrl, wr_stat, clr, stall;
  logic        unused;

  pwm_sync_edge u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pwm_i   (cio_pwm_i),
    .inv_i   (inv_q),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // A request is taken only while not acknowledging, so a held
  // valid_i is served every other cycle.
  assign acc     = valid_i & ~ready_q;
  assign wr      = acc & we_i;
  assign rd      = acc & ~we_i;
  assign idx     = addr_i[7:2];
  assign wd      = 32'(wdata_i);
  assign wr_ctrl = wr && (idx == IDX_CTRL);
  assign wr_stat = wr && (idx == IDX_STATUS);
  assign clr     = wr_ctrl & wd[CTRL_CLR];
  assign unused  = ^{addr_i[BITS-1:8], addr_i[1:0]};

  // Timeout only matters while measuring; a coincident rise wins.
  assign stall = st_q[1] && (tmo_q != 32'd0)
              && (cp_q >= tmo_q) && !rise;

  always_comb begin
    rmux = 32'd0;
    unique case (1'b1)
      idx == IDX_CTRL:
        rmux = {29'd0, irqen_q, inv_q, en_q};
      idx == IDX_STATUS:
        rmux = {28'd0, level, stl_q, ovf_q, vld_q};
      idx == IDX_HIGH:    rmux = hi_q;
      idx == IDX_PERIOD:  rmux = per_q;
      idx == IDX_EDGES:   rmux = edg_q;
      idx == IDX_TIMEOUT: rmux = tmo_q;
      default:            rmux = 32'd0;
    endcase
  end

  assign rdata_d = rd ? BITS'(rmux) : rdata_q;

  always_comb begin
    en_d    = en_q;
    inv_d   = inv_q;
    irqen_d = irqen_q;
    tmo_d   = tmo_q;
    if (wr_ctrl) begin
      en_d    = wd[CTRL_EN];
      inv_d   = wd[CTRL_INV];
      irqen_d = wd[CTRL_IRQ];
    end
    if (wr && (idx == IDX_TIMEOUT)) tmo_d = wd;
  end

  always_comb begin
    st_d  = st_q;
    cp_d  = cp_q;
    ch_d  = ch_q;
    hi_d  = hi_q;
    per_d = per_q;
    edg_d = edg_q;
    vld_d = vld_q;
    ovf_d = ovf_q;
    stl_d = stl_q;
    // W1C first so a same-cycle hardware set below wins.
    if (wr_stat) begin
      vld_d = vld_q & ~wd[ST_VALID];
      ovf_d = ovf_q & ~wd[ST_OVF];
      stl_d = stl_q & ~wd[ST_STALL];
    end
    if (en_q && rise) edg_d = edg_q + 32'd1;
    if (!en_q) begin
      st_d = S_IDLE;
    end else begin
      if (st_q != S_IDLE) begin
        cp_d = rise ? 32'd1 : sat_inc(cp_q);
        if (rise) ch_d = 32'd1;
        else if (st_q == S_HIGH && !fall) ch_d = sat_inc(ch_q);
      end
      unique case (st_q)
        S_IDLE: st_d = S_ARM;
        S_ARM:  if (rise) st_d = S_HIGH;
        S_HIGH: if (fall) st_d = S_LOW;
        default: begin
          if (rise) begin
            st_d  = S_HIGH;
            per_d = cp_q;
            hi_d  = ch_q;
            vld_d = 1'b1;
            if (vld_q) ovf_d = 1'b1;
          end
        end
      endcase
      if (stall) begin
        stl_d = 1'b1;
        st_d  = S_ARM;
      end
    end
    if (clr) begin
      cp_d  = 32'd0;
      ch_d  = 32'd0;
      hi_d  = 32'd0;
      per_d = 32'd0;
      edg_d = 32'd0;
      vld_d = 1'b0;
      ovf_d = 1'b0;
      stl_d = 1'b0;
      st_d  = en_d ? S_ARM : S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      irqen_q <= 1'b0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      stl_q   <= 1'b0;
      hi_q    <= 32'd0;
      per_q   <= 32'd0;
      edg_q   <= 32'd0;
      tmo_q   <= 32'd0;
      cp_q    <= 32'd0;
      ch_q    <= 32'd0;
      st_q    <= S_IDLE;
    end else begin
      ready_q <= acc;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      inv_q   <= inv_d;
      irqen_q <= irqen_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      stl_q   <= stl_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      edg_q   <= edg_d;
      tmo_q   <= tmo_d;
      cp_q    <= cp_d;
      ch_q    <= ch_d;
      st_q    <= st_d;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign irq_o   = vld_q & irqen_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and randomized PWM
// waveforms compared against expectations derived from edge timing.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        pwm;
  logic        irq;

  int  checks = 0;
  int  errors = 0;
  time t_last = 0;
  time t_prev = 0;
  logic [31:0] last_high = 0;

  pwm_capture #(.BITS(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .ready_o   (ready),
    .rdata_o   (rdata),
    .cio_pwm_i (pwm),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [5:0] idx,
                     input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    valid = 1'b1;
    we    = w;
    addr  = {24'd0, idx, 2'b00};
    wdata = d;
    @(negedge clk);
    valid = 1'b0;
    we    = 1'b0;
    chk("ack", {31'd0, ready}, 32'd1);
    q = rdata;
  endtask

  task automatic wr(input logic [5:0] idx, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, idx, d, q);
  endtask

  task automatic rd(input logic [5:0] idx, output logic [31:0] q);
    bus(1'b0, idx, 32'd0, q);
  endtask

  // Cycle-aligned square wave; input rise times feed the period model.
  task automatic drive(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      pwm    = 1'b1;
      t_prev = t_last;
      t_last = $time;
      repeat (h) @(negedge clk);
      pwm = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] meas_period();
    return 32'((t_last - t_prev) / 10);
  endfunction

  // n periods of h high / l low after a clear; inverted input
  // swaps which phase counts as high.
  task automatic trial(input int h, input int l, input int n,
                       input logic inv);
    logic [31:0] q, eh, ep, es, ec;
    pwm = 1'b0;
    ec  = 32'h5 | (32'(inv) << 1);
    wr(6'd0, ec);
    repeat (5) @(negedge clk);
    wr(6'd0, ec | 32'h8);
    drive(h, l, n);
    repeat (6) @(negedge clk);
    eh = (n >= 2) ? 32'(inv ? l : h) : 32'd0;
    ep = (n >= 2) ? 32'(h + l) : 32'd0;
    es = {28'd0, inv, 1'b0, (n >= 3), (n >= 2)};
    rd(6'd2, q); chk("high", q, eh);
    rd(6'd3, q); chk("period", q, ep);
    rd(6'd4, q); chk("edges", q, 32'(n));
    rd(6'd1, q); chk("status", q, es);
    rd(6'd0, q); chk("ctrl", q, ec);
    chk("irq", {31'd0, irq}, {31'd0, (n >= 2)});
    last_high = eh;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    rst   = 1'b1;
    valid = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    pwm   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(6'(i), q);
      chk("rst_reg", q, 32'd0);
    end

    // 3 high / 7 low, then overflow and W1C
    trial(3, 7, 2, 1'b0);
    drive(3, 7, 1);
    repeat (6) @(negedge clk);
    rd(6'd1, q); chk("ovf_status", q, 32'h3);
    rd(6'd2, q); chk("ovf_high", q, 32'd3);
    wr(6'd1, 32'h3);
    rd(6'd1, q); chk("w1c_status", q, 32'h0);

    // inverted 3/7 wave
    trial(3, 7, 2, 1'b1);

    for (int t = 0; t < 8; t++) begin
      trial($urandom_range(9, 1), $urandom_range(9, 1),
            $urandom_range(4, 1), 1'(($urandom_range(1, 0))));
    end

    // held valid_i: acknowledge every other cycle
    @(negedge clk);
    valid = 1'b1;
    we    = 1'b0;
    addr  = 32'd2 << 2;
    chk("hold_rdy0", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("hold_rdy1", {31'd0, ready}, 32'd1);
    chk("hold_data", rdata, last_high);
    @(negedge clk);
    chk("hold_rdy2", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("hold_rdy3", {31'd0, ready}, 32'd1);
    valid = 1'b0;
    rd(6'd9, q); chk("idx9", q, 32'd0);
    wr(6'd2, 32'hDEAD);
    rd(6'd2, q); chk("ro_high", q, last_high);
    wr(6'd5, 32'h1234);
    rd(6'd5, q); chk("timeout_rw", q, 32'h1234);

    // stall after a single rise
    pwm = 1'b0;
    wr(6'd0, 32'h1);
    repeat (5) @(negedge clk);
    wr(6'd5, 32'd20);
    wr(6'd0, 32'h9);
    drive(3, 9, 1);
    rd(6'd1, q); chk("stall_early", q, 32'h0);
    repeat (20) @(negedge clk);
    rd(6'd1, q); chk("stall_set", q, 32'h4);
    wr(6'd1, 32'h4);
    rd(6'd1, q); chk("stall_w1c", q, 32'h0);
    drive(3, 5, 1);
    rd(6'd1, q); chk("rearm_nopub", q, 32'h0);
    drive(3, 6, 1);
    rd(6'd1, q); chk("rearm_pub", q, 32'h1);
    rd(6'd3, q); chk("rearm_period", q, meas_period());
    rd(6'd2, q); chk("rearm_high", q, 32'd3);

    // reset in the middle of a high phase
    wr(6'd0, 32'h5);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    rd(6'd5, q);
    pwm = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    chk("async_ready", {31'd0, ready}, 32'd0);
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(6'(i), q);
      chk("post_rst_reg", q, 32'd0);
    end
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    wr(6'd0, 32'h1);
    repeat (3) @(negedge clk);
    drive(3, 4, 1);
    rd(6'd1, q); chk("first_rise", q, 32'h0);
    drive(3, 6, 1);
    rd(6'd1, q); chk("second_rise", q, 32'h1);
    rd(6'd3, q); chk("post_rst_per", q, meas_period());
    rd(6'd2, q); chk("post_rst_high", q, 32'd3);
    rd(6'd4, q); chk("post_rst_edges", q, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
